rca_accumulator: RTL

RCA_ACCUMULATOR -- requirements
Module: rca_accumulator

---
 rtl/rca_accumulator_pkg.sv | 15 +
 rtl/rca_acc_ctrl.sv | 57 +++++
 rtl/rca_accumulator.sv | 70 +++++++
 3 files changed

// File: rtl/rca_accumulator_pkg.sv
// Shared types and constants for the ripple-carry-adder result accumulator.
// Holds the batch FSM state encoding and the width of one adder result.
package rca_accumulator_pkg;

    // One accepted result is {carry, sum[2:0]}, i.e. 0..15.
    localparam int RES_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/rca_acc_ctrl.sv
// Batch controller for rca_accumulator: decides when a result is loaded,
// when the held batch is cleared, and drives the two handshake flags.
module rca_acc_ctrl
    import rca_accumulator_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       flush,
    input  logic       last,
    input  logic       out_ready,
    output logic       load,
    output logic       clear,
    output logic       in_ready,
    output logic       out_valid,
    output acc_state_t state
);

    acc_state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; ready depends only on registered state, never on valid.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        clear      = 1'b0;
        in_ready   = (state != DONE);
        out_valid  = (state == DONE);
        case (state)
            IDLE, ACCUM: begin
                if (in_valid) begin
                    load = 1'b1;
                    // A flush coincident with a transfer keeps that value.
                    state_next = (last || flush) ? DONE : ACCUM;
                end else if (flush && (state == ACCUM)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/rca_accumulator.sv
// Accumulates 3-bit ripple-carry-adder results (with carry) into batches of
// BATCH_LEN, tracking a wrap flag, and presents each batch total downstream.
module rca_accumulator
    import rca_accumulator_pkg::*;
#(
    parameter int BATCH_LEN = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       in_sum,
    input  logic             in_carry,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] acc_total,
    output logic [3:0]       acc_count,
    output logic             acc_overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH_LEN - 1);

    logic             load;
    logic             clear;
    logic             last;
    logic [SUM_W-1:0] sum_next;
    acc_state_t       ctrl_state;

    // The extra top bit of the sum is the wrap indication for this add.
    assign sum_next = {1'b0, acc_total} + SUM_W'({in_carry, in_sum});
    assign last     = (acc_count == LAST_CNT);

    rca_acc_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .flush     (flush),
        .last      (last),
        .out_ready (out_ready),
        .load      (load),
        .clear     (clear),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .state     (ctrl_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_total    <= '0;
            acc_count    <= '0;
            acc_overflow <= 1'b0;
        end else if (clear) begin
            acc_total    <= '0;
            acc_count    <= '0;
            acc_overflow <= 1'b0;
        end else if (load) begin
            acc_total    <= sum_next[ACC_W-1:0];
            acc_count    <= acc_count + 4'd1;
            acc_overflow <= acc_overflow | sum_next[ACC_W];
        end
    end

    // A held batch always contains at least one result.
    assert property (@(posedge clk) disable iff (rst)
        (ctrl_state == DONE) |-> (acc_count != '0));

endmodule
